// File: rtl/modulation_ram_sched.sv
// Frame scheduler for the dual-port modulation-result RAM.
// Sequences one codeword: write (2 symbols/cycle), hold until the
// demodulator asks for it, then stream it back out 2 symbols/cycle.
module modulation_ram_sched #(
  parameter int CodeLen      = 256,
  parameter int CodeLen_bits = 8,
  parameter int DataWidth    = 15,
  parameter int RdLatency    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    frame_start,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DataWidth-1:0]    wr_data_a,
  input  logic [DataWidth-1:0]    wr_data_b,
  input  logic                    rd_req,
  output logic                    rd_ack,
  output logic [CodeLen_bits-1:0] ram_addra,
  output logic [CodeLen_bits-1:0] ram_addrb,
  output logic                    ram_ena,
  output logic                    ram_enb,
  output logic                    ram_wea,
  output logic                    ram_web,
  output logic [DataWidth-1:0]    ram_dina,
  output logic [DataWidth-1:0]    ram_dinb,
  input  logic [DataWidth-1:0]    ram_douta,
  input  logic [DataWidth-1:0]    ram_doutb,
  output logic                    rd_valid,
  output logic [DataWidth-1:0]    rd_data_a,
  output logic [DataWidth-1:0]    rd_data_b,
  output logic                    rd_last,
  output logic                    frame_done,
  output logic [2:0]              state_o,
  output logic                    err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    FULL  = 3'd2,
    READ  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // One extra bit so the pointer can hold CodeLen itself without wrapping.
  localparam int PW = CodeLen_bits + 1;
  localparam logic [PW-1:0] LastPair = PW'(CodeLen - 2);
  localparam logic [PW-1:0] EndPtr   = PW'(CodeLen);
  localparam logic [PW-1:0] PtrStep  = PW'(2);

  state_t                 state;
  logic [PW-1:0]          wptr;
  logic [PW-1:0]          rptr;
  logic [RdLatency-1:0]   vld_pipe;
  logic [RdLatency-1:0]   last_pipe;

  assign wr_ready  = (state == WRITE);
  assign rd_data_a = ram_douta;
  assign rd_data_b = ram_doutb;
  assign state_o   = state;

  // Frame FSM, RAM port control and read-valid pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      ram_addra  <= '0;
      ram_addrb  <= '0;
      ram_ena    <= 1'b0;
      ram_enb    <= 1'b0;
      ram_wea    <= 1'b0;
      ram_web    <= 1'b0;
      ram_dina   <= '0;
      ram_dinb   <= '0;
      rd_ack     <= 1'b0;
      vld_pipe   <= '0;
      last_pipe  <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      ram_ena    <= 1'b0;
      ram_enb    <= 1'b0;
      ram_wea    <= 1'b0;
      ram_web    <= 1'b0;
      rd_ack     <= 1'b0;
      vld_pipe   <= '0;
      last_pipe  <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      ram_ena <= 1'b0;
      ram_enb <= 1'b0;
      ram_wea <= 1'b0;
      ram_web <= 1'b0;
      rd_ack  <= 1'b0;

      // NOTE: non-blocking assignments here let every stage take its
      // neighbour's pre-edge value, giving a true shift register.
      for (int i = RdLatency - 1; i > 0; i--) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      vld_pipe[0]  <= 1'b0;
      last_pipe[0] <= 1'b0;

      rd_valid   <= vld_pipe[RdLatency-1];
      rd_last    <= last_pipe[RdLatency-1];
      frame_done <= last_pipe[RdLatency-1];

      if (frame_start && state != IDLE) err <= 1'b1;
      if (wr_valid && (state == FULL || state == READ || state == DRAIN)) err <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= WRITE;
            wptr  <= '0;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            ram_ena   <= 1'b1;
            ram_enb   <= 1'b1;
            ram_wea   <= 1'b1;
            ram_web   <= 1'b1;
            ram_addra <= wptr[CodeLen_bits-1:0];
            ram_addrb <= {wptr[CodeLen_bits-1:1], 1'b1};
            ram_dina  <= wr_data_a;
            ram_dinb  <= wr_data_b;
            wptr      <= wptr + PtrStep;
            if (wptr == LastPair) state <= FULL;
          end
        end
        FULL: begin
          if (rd_req) begin
            state       <= READ;
            rd_ack      <= 1'b1;
            ram_ena     <= 1'b1;
            ram_enb     <= 1'b1;
            ram_addra   <= '0;
            ram_addrb   <= CodeLen_bits'(1);
            rptr        <= PtrStep;
            vld_pipe[0] <= 1'b1;
          end
        end
        READ: begin
          if (rptr == EndPtr) begin
            state <= DRAIN;
          end else begin
            ram_ena      <= 1'b1;
            ram_enb      <= 1'b1;
            ram_addra    <= rptr[CodeLen_bits-1:0];
            ram_addrb    <= {rptr[CodeLen_bits-1:1], 1'b1};
            rptr         <= rptr + PtrStep;
            vld_pipe[0]  <= 1'b1;
            last_pipe[0] <= (rptr == LastPair);
          end
        end
        DRAIN: begin
          if (rd_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modulation_ram_sched.sv
// Self-checking bench for modulation_ram_sched: random frames written
// through a behavioural RAM, read back and compared against the frame
// the bench itself sent, plus timing, error and abort behaviour.
module tb_modulation_ram_sched;

  localparam int N  = 8;
  localparam int AB = 3;
  localparam int DW = 15;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          frame_start = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data_a = '0;
  logic [DW-1:0] wr_data_b = '0;
  logic          rd_req = 1'b0;
  logic          rd_ack;
  logic [AB-1:0] ram_addra, ram_addrb;
  logic          ram_ena, ram_enb, ram_wea, ram_web;
  logic [DW-1:0] ram_dina, ram_dinb, ram_douta, ram_doutb;
  logic          rd_valid, rd_last, frame_done, err;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic [2:0]    state_o;

  modulation_ram_sched #(
    .CodeLen(N), .CodeLen_bits(AB), .DataWidth(DW), .RdLatency(L)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .frame_start(frame_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .rd_req(rd_req), .rd_ack(rd_ack),
    .ram_addra(ram_addra), .ram_addrb(ram_addrb),
    .ram_ena(ram_ena), .ram_enb(ram_enb), .ram_wea(ram_wea), .ram_web(ram_web),
    .ram_dina(ram_dina), .ram_dinb(ram_dinb),
    .ram_douta(ram_douta), .ram_doutb(ram_doutb),
    .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_last(rd_last), .frame_done(frame_done), .state_o(state_o), .err(err)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural dual-port RAM with L-cycle read latency.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] pa [L];
  logic [DW-1:0] pb [L];
  initial for (int i = 0; i < N; i++) mem[i] = '0;
  initial for (int i = 0; i < L; i++) begin pa[i] = '0; pb[i] = '0; end
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb && ram_web) mem[ram_addrb] <= ram_dinb;
    for (int i = L - 1; i > 0; i--) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
    pa[0] <= mem[ram_addra];
    pb[0] <= mem[ram_addrb];
  end
  assign ram_douta = pa[L-1];
  assign ram_doutb = pb[L-1];

  // Event logs filled by the monitor.
  typedef struct {
    int          cyc;
    logic [AB-1:0] a;
    logic [AB-1:0] b;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    bit          both;
  } wr_ev_t;
  typedef struct {
    int          cyc;
    logic [AB-1:0] a;
    logic [AB-1:0] b;
  } iss_ev_t;
  typedef struct {
    int          cyc;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } rd_ev_t;

  wr_ev_t  wlog[$];
  iss_ev_t ilog[$];
  rd_ev_t  vlog[$];
  int      acklog[$];
  int      lastlog[$];
  int      donelog[$];

  always @(negedge clk) begin
    if (rst) begin
      if (ram_ena && ram_wea)
        wlog.push_back('{cyc, ram_addra, ram_addrb, ram_dina, ram_dinb, ram_enb && ram_web});
      if (ram_ena && !ram_wea)
        ilog.push_back('{cyc, ram_addra, ram_addrb});
      if (rd_valid)   vlog.push_back('{cyc, rd_data_a, rd_data_b});
      if (rd_ack)     acklog.push_back(cyc);
      if (rd_last)    lastlog.push_back(cyc);
      if (frame_done) donelog.push_back(cyc);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: what the bench sent, and the edge each pair was taken.
  logic [DW-1:0] exp_frame [N];
  int            acc_edge [N/2];

  task automatic clear_logs();
    wlog.delete(); ilog.delete(); vlog.delete();
    acklog.delete(); lastlog.delete(); donelog.delete();
  endtask

  // mode 0: back-to-back, 1: 1,0,0,1,0,0..., 2: random gaps
  task automatic write_frame(input int mode, input bit hold_rd, input bit fs_with_valid);
    int acc;
    clear_logs();
    rd_req      = hold_rd;
    frame_start = 1'b1;
    wr_valid    = fs_with_valid;
    wr_data_a   = 15'h7abc;
    wr_data_b   = 15'h7abd;
    tick();
    frame_start = 1'b0;
    check("state_write", 64'(state_o), 64'd1);
    acc = 0;
    for (int k = 0; k < 200 && acc < N/2; k++) begin
      logic v;
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (k % 3 == 0);
      else                v = 1'($urandom_range(0, 1));
      wr_valid  = v;
      wr_data_a = 15'($urandom);
      wr_data_b = 15'($urandom);
      if (v) begin
        exp_frame[2*acc]   = wr_data_a;
        exp_frame[2*acc+1] = wr_data_b;
      end
      tick();
      if (v) begin
        acc_edge[acc] = cyc;
        acc++;
      end
      check("state_during_write", 64'(state_o), (acc == N/2) ? 64'd2 : 64'd1);
    end
    wr_valid = 1'b0;
    check("wr_ready_full", 64'(wr_ready), 64'd0);
  endtask

  task automatic check_writes();
    check("wr_strobe_count", 64'(wlog.size()), 64'(N/2));
    for (int i = 0; i < wlog.size() && i < N/2; i++) begin
      check("wr_addra", 64'(wlog[i].a),  64'(2*i));
      check("wr_addrb", 64'(wlog[i].b),  64'(2*i+1));
      check("wr_dina",  64'(wlog[i].da), 64'(exp_frame[2*i]));
      check("wr_dinb",  64'(wlog[i].db), 64'(exp_frame[2*i+1]));
      check("wr_portb", 64'(wlog[i].both), 64'd1);
      check("wr_cycle", 64'(wlog[i].cyc), 64'(acc_edge[i]));
    end
  endtask

  task automatic read_frame(input bit fs_in_read, input bit flush_mid);
    int t;
    int f;
    int late;
    rd_req = 1'b1;
    tick();
    t = cyc;
    rd_req = 1'b0;
    if (flush_mid) begin
      tick();
      tick();
      flush = 1'b1;
      tick();
      f = cyc;
      flush = 1'b0;
      check("flush_ena",   64'(ram_ena),  64'd0);
      check("flush_state", 64'(state_o),  64'd0);
      repeat (6) tick();
      late = 0;
      foreach (vlog[i]) if (vlog[i].cyc >= f) late++;
      check("flush_no_valid", 64'(late), 64'd0);
      check("flush_no_done",  64'(donelog.size()), 64'd0);
      check("flush_no_last",  64'(lastlog.size()), 64'd0);
      check("flush_idle",     64'(state_o), 64'd0);
      return;
    end
    while (cyc < t + N/2 + L) begin
      frame_start = fs_in_read && (cyc == t + 1);
      if (cyc == t + N/2 + L - 1) check("state_drain", 64'(state_o), 64'd4);
      tick();
    end
    frame_start = 1'b0;
    check("state_idle_end", 64'(state_o), 64'd0);
    tick();
    tick();
    check("ack_count", 64'(acklog.size()), 64'd1);
    if (acklog.size() > 0) check("ack_cycle", 64'(acklog[0]), 64'(t));
    check("issue_count", 64'(ilog.size()), 64'(N/2));
    for (int i = 0; i < ilog.size() && i < N/2; i++) begin
      check("issue_addra", 64'(ilog[i].a), 64'(2*i));
      check("issue_addrb", 64'(ilog[i].b), 64'(2*i+1));
      check("issue_cycle", 64'(ilog[i].cyc), 64'(t + i));
    end
    check("valid_count", 64'(vlog.size()), 64'(N/2));
    for (int i = 0; i < vlog.size() && i < N/2; i++) begin
      check("rd_data_a",   64'(vlog[i].a), 64'(exp_frame[2*i]));
      check("rd_data_b",   64'(vlog[i].b), 64'(exp_frame[2*i+1]));
      check("valid_cycle", 64'(vlog[i].cyc), 64'(t + L + i));
    end
    check("last_count", 64'(lastlog.size()), 64'd1);
    if (lastlog.size() > 0) check("last_cycle", 64'(lastlog[0]), 64'(t + N/2 + L - 1));
    check("done_count", 64'(donelog.size()), 64'd1);
    if (donelog.size() > 0) check("done_cycle", 64'(donelog[0]), 64'(t + N/2 + L - 1));
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({state_o, ram_ena, ram_enb, ram_wea, ram_web, wr_ready, rd_ack,
                rd_valid, rd_last, frame_done, err, ram_addra, ram_addrb,
                ram_dina, ram_dinb});
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #2;
    check("reset_outputs", outs_vec(), 64'd0);
    #20;
    rst = 1'b1;
    tick();
    check("idle_after_reset", 64'(state_o), 64'd0);

    // Frame 1: back-to-back writes; a frame_start+wr_valid pair is not written.
    write_frame(0, 1'b0, 1'b1);
    read_frame(1'b0, 1'b0);
    check_writes();
    check("err_frame1", 64'(err), 64'd0);

    // Frame 2: gapped writes with rd_req held high from IDLE through WRITE.
    write_frame(1, 1'b1, 1'b0);
    check("no_early_ack", 64'(acklog.size()), 64'd0);
    check("err_rd_hold", 64'(err), 64'd0);
    read_frame(1'b0, 1'b0);
    check_writes();

    // Frame 3: wr_valid in FULL and frame_start in READ raise sticky err.
    write_frame(2, 1'b0, 1'b0);
    wr_valid  = 1'b1;
    wr_data_a = 15'h1234;
    wr_data_b = 15'h4321;
    tick();
    wr_valid = 1'b0;
    check("err_wr_in_full", 64'(err), 64'd1);
    read_frame(1'b1, 1'b0);
    check_writes();
    check("err_sticky", 64'(err), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("err_flushed", 64'(err), 64'd0);

    // Frame 4: flush in the middle of READ.
    write_frame(2, 1'b0, 1'b0);
    read_frame(1'b0, 1'b1);

    // Asynchronous reset in the middle of a write.
    clear_logs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wr_valid = 1'b1;
    repeat (2) begin
      wr_data_a = 15'($urandom);
      wr_data_b = 15'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", outs_vec(), 64'd0);
    #2;
    rst = 1'b1;
    tick();
    check("idle_after_async_reset", 64'(state_o), 64'd0);

    // Frame 5: full frame after the reset.
    write_frame(2, 1'b0, 1'b0);
    read_frame(1'b0, 1'b0);
    check_writes();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
